// File: rtl/dmac_channel_datapath.sv
// dmac_channel_datapath
//    Datapath half of one DMA channel. Holds the source/destination address
//    counters, remaining-transfer and burst-length bookkeeping, the beat
//    counter and the read-to-write data FIFO. The channel controller FSM
//    drives the select/enable strobes and branches on the status flags.
//
// Ports
//    clk, rst                 clock, synchronous active-high reset
//    cfg_*                    programmed channel configuration
//    s_/d_/t_sel, s_/d_/ts_en source, destination, remaining-size load/step
//    b_sel, burst_en          burst-length load source and enable
//    count_en                 beat counter advance
//    h_sel                    HAddr mux, 1 = destination, 0 = source
//    wr_en, rd_en, HRData     FIFO push of read data / pop to HWData
//    HAddr, HWData            AHB address and registered write data
//    bsz, tslb, tsz           burst done, remaining < burst, remaining == 0
//    fifo_full, fifo_empty    FIFO status
//    fifo_ovf, fifo_udf       sticky overflow / underflow
//
// Strobe semantics: there is no valid/ready pairing here. Every strobe is a
// single-cycle command sampled on the rising edge; each register follows only
// its own enable/select pair, and a push or pop that cannot complete is
// dropped and recorded in the sticky error flags instead of stalling.
module dmac_channel_datapath #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int CNT_W      = 16,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] cfg_src_addr,
   input  logic [ADDR_W-1:0] cfg_dst_addr,
   input  logic [CNT_W-1:0]  cfg_trans_size,
   input  logic [CNT_W-1:0]  cfg_burst_size,
   input  logic [1:0]        cfg_hsize,
   input  logic              s_sel,
   input  logic              d_sel,
   input  logic              t_sel,
   input  logic              s_en,
   input  logic              d_en,
   input  logic              ts_en,
   input  logic              b_sel,
   input  logic              burst_en,
   input  logic              count_en,
   input  logic              h_sel,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [DATA_W-1:0] HRData,
   output logic [ADDR_W-1:0] HAddr,
   output logic [DATA_W-1:0] HWData,
   output logic              bsz,
   output logic              tslb,
   output logic              tsz,
   output logic              fifo_full,
   output logic              fifo_empty,
   output logic              fifo_ovf,
   output logic              fifo_udf
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [CNT_W-1:0]  r_rem;
   logic [CNT_W-1:0]  r_burst_len;
   logic [CNT_W-1:0]  r_beat_cnt;
   logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W:0]    r_count;
   logic [DATA_W-1:0] r_hwdata;
   logic              r_ovf;
   logic              r_udf;

   logic [1:0]        w_hsize_eff;
   logic [ADDR_W-1:0] w_step;
   logic [CNT_W-1:0]  w_rem_sub;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;

   // hsize 3 is not a legal AHB beat for this channel; treat it as a word.
   assign w_hsize_eff = (cfg_hsize == 2'd3) ? 2'd2 : cfg_hsize;
   assign w_step      = ADDR_W'(1) << w_hsize_eff;
   // Saturating subtract so a short last burst never wraps the remaining size.
   assign w_rem_sub   = (r_rem > r_burst_len) ? (r_rem - r_burst_len) : '0;

   assign w_full  = (r_count == (PTR_W+1)'(FIFO_DEPTH));
   assign w_empty = (r_count == '0);
   assign w_pop   = rd_en && !w_empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO succeeds.
   assign w_push  = wr_en && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_src       <= '0;
         r_dst       <= '0;
         r_rem       <= '0;
         r_burst_len <= '0;
         r_beat_cnt  <= '0;
      end else begin
         if (s_en) r_src <= s_sel ? cfg_src_addr : (r_src + w_step);
         if (d_en) r_dst <= d_sel ? cfg_dst_addr : (r_dst + w_step);
         if (ts_en) r_rem <= t_sel ? cfg_trans_size : w_rem_sub;
         // r_rem on the right is the pre-update value even if ts_en fires too.
         if (burst_en) r_burst_len <= b_sel ? r_rem : cfg_burst_size;
         // Counting across a burst boundary restarts at beat 1 of the next burst.
         if (count_en) r_beat_cnt <= bsz ? CNT_W'(1) : (r_beat_cnt + CNT_W'(1));
         else if (burst_en) r_beat_cnt <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_hwdata <= '0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_hwdata <= r_mem[r_rd_ptr];
         end
         if (w_push && !w_pop)      r_count <= r_count + (PTR_W+1)'(1);
         else if (w_pop && !w_push) r_count <= r_count - (PTR_W+1)'(1);
         if (wr_en && !w_push) r_ovf <= 1'b1;
         if (rd_en && w_empty) r_udf <= 1'b1;
      end
   end

   // Storage needs no reset: the pointers and count define which words are live.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= HRData;
   end

   assign HAddr      = h_sel ? r_dst : r_src;
   assign HWData     = r_hwdata;
   assign bsz        = (r_burst_len != '0) && (r_beat_cnt == r_burst_len);
   assign tsz        = (r_rem == '0);
   assign tslb       = (r_rem < cfg_burst_size);
   assign fifo_full  = w_full;
   assign fifo_empty = w_empty;
   assign fifo_ovf   = r_ovf;
   assign fifo_udf   = r_udf;

endmodule

// File: tb/tb_dmac_channel_datapath.sv
// tb_dmac_channel_datapath
//    Directed bench for dmac_channel_datapath. A reference model of the
//    channel (plain arithmetic plus a queue for the FIFO) is advanced on each
//    rising edge; a compare process checks every output against it on each
//    falling edge, and the directed sequence adds literal expectations.
module tb_dmac_channel_datapath;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] cfg_src_addr = '0;
   logic [31:0] cfg_dst_addr = '0;
   logic [15:0] cfg_trans_size = '0;
   logic [15:0] cfg_burst_size = '0;
   logic [1:0]  cfg_hsize = '0;
   logic        s_sel = 0, d_sel = 0, t_sel = 0;
   logic        s_en = 0, d_en = 0, ts_en = 0;
   logic        b_sel = 0, burst_en = 0, count_en = 0, h_sel = 0;
   logic        wr_en = 0, rd_en = 0;
   logic [31:0] HRData = '0;
   logic [31:0] HAddr, HWData;
   logic        bsz, tslb, tsz, fifo_full, fifo_empty, fifo_ovf, fifo_udf;

   int checks = 0;
   int errors = 0;
   bit chk_on = 0;

   dmac_channel_datapath dut (
      .clk(clk), .rst(rst),
      .cfg_src_addr(cfg_src_addr), .cfg_dst_addr(cfg_dst_addr),
      .cfg_trans_size(cfg_trans_size), .cfg_burst_size(cfg_burst_size),
      .cfg_hsize(cfg_hsize),
      .s_sel(s_sel), .d_sel(d_sel), .t_sel(t_sel),
      .s_en(s_en), .d_en(d_en), .ts_en(ts_en),
      .b_sel(b_sel), .burst_en(burst_en), .count_en(count_en), .h_sel(h_sel),
      .wr_en(wr_en), .rd_en(rd_en), .HRData(HRData),
      .HAddr(HAddr), .HWData(HWData),
      .bsz(bsz), .tslb(tslb), .tsz(tsz),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .fifo_ovf(fifo_ovf), .fifo_udf(fifo_udf)
   );

   // clock / reset
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [31:0] m_src, m_dst, m_hw;
   logic [15:0] m_rem, m_blen, m_beat;
   logic        m_ovf, m_udf;
   logic [31:0] exp_q[$];   // FIFO contents, head at index 0

   always @(posedge clk) begin : model
      logic [31:0] step;
      logic [15:0] n_rem, n_blen, n_beat;
      logic        done;
      if (rst) begin
         m_src = 0; m_dst = 0; m_hw = 0; m_rem = 0; m_blen = 0; m_beat = 0;
         m_ovf = 0; m_udf = 0;
         exp_q.delete();
      end else begin
         step = 32'd1 << ((cfg_hsize == 2'd3) ? 2 : int'(cfg_hsize));
         done = (m_blen != 0) && (m_beat == m_blen);
         n_rem = m_rem;
         if (ts_en) n_rem = t_sel ? cfg_trans_size : ((m_rem >= m_blen) ? m_rem - m_blen : 16'd0);
         n_blen = m_blen;
         if (burst_en) n_blen = b_sel ? m_rem : cfg_burst_size;
         n_beat = m_beat;
         if (count_en) n_beat = done ? 16'd1 : m_beat + 16'd1;
         else if (burst_en) n_beat = 0;
         if (s_en) m_src = s_sel ? cfg_src_addr : m_src + step;
         if (d_en) m_dst = d_sel ? cfg_dst_addr : m_dst + step;
         m_rem = n_rem; m_blen = n_blen; m_beat = n_beat;
         // pop first so that a pop frees a slot for a same-cycle push
         if (rd_en) begin
            if (exp_q.size() > 0) m_hw = exp_q.pop_front();
            else m_udf = 1;
         end
         if (wr_en) begin
            if (exp_q.size() < 16) exp_q.push_back(HRData);
            else m_ovf = 1;
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         check("haddr", HAddr, h_sel ? m_dst : m_src);
         check("hwdata", HWData, m_hw);
         check("bsz", 32'(bsz), 32'((m_blen != 0) && (m_beat == m_blen)));
         check("tsz", 32'(tsz), 32'(m_rem == 0));
         check("tslb", 32'(tslb), 32'(m_rem < cfg_burst_size));
         check("full", 32'(fifo_full), 32'(exp_q.size() == 16));
         check("empty", 32'(fifo_empty), 32'(exp_q.size() == 0));
         check("ovf", 32'(fifo_ovf), 32'(m_ovf));
         check("udf", 32'(fifo_udf), 32'(m_udf));
      end
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      {s_sel, d_sel, t_sel, s_en, d_en, ts_en, b_sel, burst_en, count_en, wr_en, rd_en} = '0;
   endtask

   initial begin
      // reset, with cfg_burst_size 0 so tslb reads 0
      rst = 1; tick(); tick(); rst = 0; chk_on = 1;
      check("rst_haddr", HAddr, 32'h0);
      check("rst_hwdata", HWData, 32'h0);
      check("rst_empty", 32'(fifo_empty), 32'd1);
      check("rst_full", 32'(fifo_full), 32'd0);
      check("rst_tsz", 32'(tsz), 32'd1);
      check("rst_tslb", 32'(tslb), 32'd0);
      check("rst_bsz", 32'(bsz), 32'd0);

      // configuration load
      cfg_src_addr = 32'h1000; cfg_dst_addr = 32'h2000;
      cfg_trans_size = 8; cfg_burst_size = 4; cfg_hsize = 2;
      s_sel = 1; d_sel = 1; t_sel = 1; s_en = 1; d_en = 1; ts_en = 1; burst_en = 1;
      tick();
      check("load_src", HAddr, 32'h1000);
      check("load_tsz", 32'(tsz), 32'd0);
      check("load_tslb", 32'(tslb), 32'd0);
      check("load_bsz", 32'(bsz), 32'd0);
      h_sel = 1; #1;
      check("load_dst", HAddr, 32'h2000);
      h_sel = 0; #1;

      // read burst into the FIFO
      for (int i = 0; i < 4; i++) begin
         check("rd_haddr", HAddr, 32'h1000 + 32'(4 * i));
         count_en = 1; s_en = 1; wr_en = 1; HRData = 32'hA0 + 32'(i);
         tick();
      end
      check("rd_bsz", 32'(bsz), 32'd1);
      check("rd_not_empty", 32'(fifo_empty), 32'd0);
      ts_en = 1; burst_en = 1; tick();   // remaining 8 -> 4
      check("rd_tsz", 32'(tsz), 32'd0);
      check("rd_tslb", 32'(tslb), 32'd0);
      check("rd_bsz_clr", 32'(bsz), 32'd0);

      // write burst out of the FIFO
      h_sel = 1; #1;
      for (int i = 0; i < 4; i++) begin
         check("wr_haddr", HAddr, 32'h2000 + 32'(4 * i));
         d_en = 1; count_en = 1; rd_en = 1;
         tick();
         check("wr_hwdata", HWData, 32'hA0 + 32'(i));
      end
      check("wr_empty", 32'(fifo_empty), 32'd1);
      check("wr_bsz", 32'(bsz), 32'd1);
      ts_en = 1; tick();
      check("wr_tsz", 32'(tsz), 32'd1);
      h_sel = 0;

      // partial last burst: trans 6, burst 4
      cfg_trans_size = 6;
      t_sel = 1; ts_en = 1; burst_en = 1; tick();
      for (int i = 0; i < 4; i++) begin count_en = 1; tick(); end
      check("pt_bsz4", 32'(bsz), 32'd1);
      ts_en = 1; tick();
      check("pt_tslb", 32'(tslb), 32'd1);
      check("pt_tsz0", 32'(tsz), 32'd0);
      b_sel = 1; burst_en = 1; tick();
      count_en = 1; tick();
      check("pt_bsz1", 32'(bsz), 32'd0);
      count_en = 1; tick();
      check("pt_bsz2", 32'(bsz), 32'd1);
      ts_en = 1; tick();
      check("pt_tsz", 32'(tsz), 32'd1);

      // burst length loads the pre-update remaining size: rem 10 -> 6, blen 10
      cfg_trans_size = 10;
      t_sel = 1; ts_en = 1; burst_en = 1; tick();
      ts_en = 1; b_sel = 1; burst_en = 1; tick();
      for (int i = 0; i < 6; i++) begin count_en = 1; tick(); end
      check("pre_bsz6", 32'(bsz), 32'd0);
      for (int i = 0; i < 4; i++) begin count_en = 1; tick(); end
      check("pre_bsz10", 32'(bsz), 32'd1);
      // count_en beats burst_en: beat restarts at 1, burst length 4
      count_en = 1; burst_en = 1; tick();
      check("cnt_win0", 32'(bsz), 32'd0);
      for (int i = 0; i < 3; i++) begin count_en = 1; tick(); end
      check("cnt_win4", 32'(bsz), 32'd1);

      // beat sizes and address wrap
      cfg_src_addr = 32'h100; s_sel = 1; s_en = 1; tick();
      cfg_hsize = 0; s_en = 1; tick(); check("step_byte", HAddr, 32'h101);
      cfg_hsize = 1; s_en = 1; tick(); check("step_half", HAddr, 32'h103);
      cfg_hsize = 3; s_en = 1; tick(); check("step_h3", HAddr, 32'h107);
      cfg_src_addr = 32'hFFFF_FFFE; s_sel = 1; s_en = 1; tick();
      cfg_hsize = 2; s_en = 1; tick(); check("wrap", HAddr, 32'h0000_0002);

      // FIFO edges
      for (int i = 0; i < 17; i++) begin
         wr_en = 1; HRData = 32'hB0 + 32'(i); tick();
         if (i == 15) begin
            check("ff_full", 32'(fifo_full), 32'd1);
            check("ff_no_ovf", 32'(fifo_ovf), 32'd0);
         end
      end
      check("ff_ovf", 32'(fifo_ovf), 32'd1);
      wr_en = 1; rd_en = 1; HRData = 32'hCC; tick();
      check("ff_pp_full", 32'(fifo_full), 32'd1);
      check("ff_pp_data", HWData, 32'hB0);
      for (int i = 0; i < 16; i++) begin
         rd_en = 1; tick();
         check("ff_drain", HWData, (i < 15) ? 32'hB1 + 32'(i) : 32'hCC);
      end
      check("ff_empty", 32'(fifo_empty), 32'd1);
      check("ff_no_udf", 32'(fifo_udf), 32'd0);
      rd_en = 1; tick();
      check("ff_udf", 32'(fifo_udf), 32'd1);
      check("ff_udf_hold", HWData, 32'hCC);
      wr_en = 1; rd_en = 1; HRData = 32'hDD; tick();
      check("ff_pp_empty", 32'(fifo_empty), 32'd0);
      check("ff_pp_hold", HWData, 32'hCC);

      // reset mid-transfer
      for (int i = 0; i < 2; i++) begin wr_en = 1; HRData = 32'hE0 + 32'(i); tick(); end
      count_en = 1; s_en = 1; tick();
      rst = 1; count_en = 1; wr_en = 1; cfg_burst_size = 0; tick();
      rst = 0;
      check("mr_haddr", HAddr, 32'h0);
      check("mr_hwdata", HWData, 32'h0);
      check("mr_empty", 32'(fifo_empty), 32'd1);
      check("mr_tsz", 32'(tsz), 32'd1);
      check("mr_bsz", 32'(bsz), 32'd0);
      check("mr_ovf", 32'(fifo_ovf), 32'd0);
      check("mr_udf", 32'(fifo_udf), 32'd0);
      tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
